// File: rtl/serdes_pkg.sv
// Shared types and width helpers for the frame serializer/deserializer.
package serdes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } tx_state_e;

    // Wide enough for GAP_CYCLES up to 15.
    localparam int GAP_CNT_W = 4;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; full/empty come from registered occupancy.
module sync_fifo
    import serdes_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = cnt_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; the pointers and count are reset, so stale words are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/frame_serdes_param.sv
// Word serializer fed by a TX FIFO, plus an independent bit-qualified deserializer.
module frame_serdes_param
    import serdes_pkg::*;
#(
    parameter int WORD_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int LSB_FIRST  = 0,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_en,
    output logic              busy,
    input  logic              ser_in,
    input  logic              ser_in_en,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_abort
);

    localparam int                   BIT_W    = cnt_w(WORD_W);
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [WORD_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    tx_state_e             state_q, state_d;
    logic [WORD_W-1:0]     tx_sh_q, tx_sh_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic                  tx_bit;

    assign in_ready = !fifo_full;
    assign busy     = (state_q != IDLE) || !fifo_empty;
    assign tx_bit   = (LSB_FIRST != 0) ? tx_sh_q[0] : tx_sh_q[WORD_W-1];
    assign ser_en   = (state_q == SHIFT);
    assign ser_out  = ser_en & tx_bit;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        tx_sh_d   = tx_sh_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                fifo_pop  = 1'b1;
                tx_sh_d   = fifo_rd_data;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                tx_sh_d   = (LSB_FIRST != 0) ? (tx_sh_q >> 1) : (tx_sh_q << 1);
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    if (GAP_CYCLES > 0) state_d = GAP;
                    else                state_d = fifo_empty ? IDLE : LOAD;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                if (gap_cnt_q == LAST_GAP) begin
                    gap_cnt_d = '0;
                    state_d   = fifo_empty ? IDLE : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_sh_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_sh_q   <= tx_sh_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    logic [WORD_W-1:0] rx_sh_q, rx_sh_d;
    logic [WORD_W-1:0] rx_shifted;
    logic [BIT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_abort_q, rx_abort_d;

    assign rx_shifted = (LSB_FIRST != 0) ? {ser_in, rx_sh_q[WORD_W-1:1]}
                                         : {rx_sh_q[WORD_W-2:0], ser_in};
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_abort   = rx_abort_q;

    // A non-zero count with the qualifier low means the frame was cut short.
    always_comb begin
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_abort_d = 1'b0;
        if (ser_in_en) begin
            rx_sh_d = rx_shifted;
            if (rx_cnt_q == LAST_BIT) begin
                rx_cnt_d   = '0;
                rx_data_d  = rx_shifted;
                rx_valid_d = 1'b1;
            end else begin
                rx_cnt_d = rx_cnt_q + BIT_W'(1);
            end
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d   = '0;
            rx_abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_abort_q <= 1'b0;
        end else begin
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_abort_q <= rx_abort_d;
        end
    end

endmodule

// File: tb/tb_frame_serdes_param.sv
// Loopback bench: a default instance (MSB first, one gap cycle) and an 8-bit LSB-first, gapless instance.
module tb_frame_serdes_param;

    typedef bit          bitq_t[$];
    typedef logic [31:0] wordq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Instance A: defaults, serial input selectable between loopback and bench drive
    logic [11:0] in_data_a = '0;
    logic        in_valid_a = 1'b0;
    logic        in_ready_a, ser_out_a, ser_en_a, busy_a, ser_in_a, ser_in_en_a;
    logic [11:0] rx_data_a;
    logic        rx_valid_a, rx_abort_a;
    logic        loop_a = 1'b1;
    logic        drv_ser_in = 1'b0;
    logic        drv_ser_en = 1'b0;

    assign ser_in_a    = loop_a ? ser_out_a : drv_ser_in;
    assign ser_in_en_a = loop_a ? ser_en_a  : drv_ser_en;

    frame_serdes_param u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .ser_out   (ser_out_a),
        .ser_en    (ser_en_a),
        .busy      (busy_a),
        .ser_in    (ser_in_a),
        .ser_in_en (ser_in_en_a),
        .rx_data   (rx_data_a),
        .rx_valid  (rx_valid_a),
        .rx_abort  (rx_abort_a)
    );

    // Instance B: 8-bit, LSB first, no gap, hard loopback
    logic [7:0] in_data_b = '0;
    logic       in_valid_b = 1'b0;
    logic       in_ready_b, ser_out_b, ser_en_b, busy_b;
    logic [7:0] rx_data_b;
    logic       rx_valid_b, rx_abort_b;

    frame_serdes_param #(
        .WORD_W     (8),
        .FIFO_DEPTH (4),
        .LSB_FIRST  (1),
        .GAP_CYCLES (0)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .ser_out   (ser_out_b),
        .ser_en    (ser_en_b),
        .busy      (busy_b),
        .ser_in    (ser_out_b),
        .ser_in_en (ser_en_b),
        .rx_data   (rx_data_b),
        .rx_valid  (rx_valid_b),
        .rx_abort  (rx_abort_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Serial bit list -> word, following the chosen bit order
    function automatic logic [31:0] pack_bits(input bitq_t b, input bit lsb);
        logic [31:0] w;
        w = '0;
        foreach (b[i]) begin
            if (lsb) w[i] = b[i];
            else     w = {w[30:0], b[i]};
        end
        return w;
    endfunction

    task automatic cmp_q(input string tag, input wordq_t got, input wordq_t exp);
        check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_%0d", tag, i), got[i], exp[i]);
    endtask

    // Reference state: words accepted by each FIFO, and what the lines actually carried
    wordq_t exp_a, tx_words_a, rx_words_a;
    wordq_t exp_b, tx_words_b, rx_words_b;
    bitq_t  cur_a, last_a, cur_b, last_b;
    int     starts_a[$], starts_b[$];
    int     idle_hi = 0, trunc = 0, aborts_a = 0, valids_a = 0, aborts_b = 0;
    int     push_cyc_a = 0;

    always @(negedge clk) begin
        if (rx_valid_a) begin valids_a++; rx_words_a.push_back(32'(rx_data_a)); end
        if (rx_abort_a) aborts_a++;
        if (rst) cur_a.delete();
        else if (ser_en_a) begin
            if (cur_a.size() == 0) starts_a.push_back(cyc);
            cur_a.push_back(ser_out_a);
            if (cur_a.size() == 12) begin
                last_a = cur_a;
                tx_words_a.push_back(pack_bits(cur_a, 1'b0));
                cur_a.delete();
            end
        end else begin
            if (ser_out_a) idle_hi++;
            if (cur_a.size() != 0) begin trunc++; cur_a.delete(); end
        end
    end

    always @(negedge clk) begin
        if (rx_valid_b) rx_words_b.push_back(32'(rx_data_b));
        if (rx_abort_b) aborts_b++;
        if (rst) cur_b.delete();
        else if (ser_en_b) begin
            if (cur_b.size() == 0) starts_b.push_back(cyc);
            cur_b.push_back(ser_out_b);
            if (cur_b.size() == 8) begin
                last_b = cur_b;
                tx_words_b.push_back(pack_bits(cur_b, 1'b1));
                cur_b.delete();
            end
        end else begin
            if (ser_out_b) idle_hi++;
            if (cur_b.size() != 0) begin trunc++; cur_b.delete(); end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [11:0] w);
        bit ok = 1'b0;
        in_data_a  = w;
        in_valid_a = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (in_ready_a) begin ok = 1'b1; break; end
        end
        if (!ok) check("push_a_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        push_cyc_a = cyc;
        if (ok) exp_a.push_back(32'(w));
    endtask

    task automatic push_b(input logic [7:0] w);
        bit ok = 1'b0;
        in_data_b  = w;
        in_valid_b = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (in_ready_b) begin ok = 1'b1; break; end
        end
        if (!ok) check("push_b_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        if (ok) exp_b.push_back(32'(w));
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            cycles(1);
            if (!busy_a && !busy_b) begin done = 1'b1; break; end
        end
        if (!done) check({tag, "_idle_timeout"}, 32'(done), 32'd1);
        cycles(4);
    endtask

    task automatic drive_rx_a(input int n, output logic [31:0] w);
        bitq_t b;
        for (int i = 0; i < n; i++) begin
            drv_ser_in = 1'($urandom_range(0, 1));
            drv_ser_en = 1'b1;
            b.push_back(drv_ser_in);
            cycles(1);
        end
        drv_ser_en = 1'b0;
        drv_ser_in = 1'b0;
        w = pack_bits(b, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ser_en"},   32'(ser_en_a),   32'd0);
        check({tag, "_ser_out"},  32'(ser_out_a),  32'd0);
        check({tag, "_busy"},     32'(busy_a),     32'd0);
        check({tag, "_in_ready"}, 32'(in_ready_a), 32'd1);
        check({tag, "_rx_data"},  32'(rx_data_a),  32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid_a), 32'd0);
        check({tag, "_rx_abort"}, 32'(rx_abort_a), 32'd0);
    endtask

    initial begin
        logic [31:0] w, last_word;
        int          v0, a0, fs;
        bit          seen;

        cycles(3);
        check_reset_outputs("rst_a");
        check("rst_b_in_ready", 32'(in_ready_b), 32'd1);
        check("rst_b_busy",     32'(busy_b),     32'd0);
        @(negedge clk) rst = 1'b0;
        cycles(2);

        // Single known word on the default instance: bit pattern, latency, loopback
        push_a(12'hA5C);
        wait_idle("a5c");
        check("a5c_frames", 32'(starts_a.size()), 32'd1);
        if (starts_a.size() > 0) check("a5c_latency", 32'(starts_a[0] - push_cyc_a), 32'd2);
        check("a5c_serial_bits", pack_bits(last_a, 1'b0), 32'b1010_0101_1100);
        check("a5c_rx_data", 32'(rx_data_a), 32'hA5C);
        check("a5c_rx_valid_pulses", 32'(valids_a), 32'd1);
        cmp_q("a5c_tx", tx_words_a, exp_a);
        cmp_q("a5c_rx", rx_words_a, exp_a);
        tx_words_a.delete(); rx_words_a.delete(); exp_a.delete(); starts_a.delete();

        // Randomised traffic with random spacing on both instances
        for (int i = 0; i < 16; i++) begin
            push_a(12'($urandom));
            push_b(8'($urandom));
            cycles($urandom_range(0, 14));
        end
        wait_idle("rand");
        cmp_q("rand_a_tx", tx_words_a, exp_a);
        cmp_q("rand_a_rx", rx_words_a, exp_a);
        cmp_q("rand_b_tx", tx_words_b, exp_b);
        cmp_q("rand_b_rx", rx_words_b, exp_b);
        tx_words_a.delete(); rx_words_a.delete(); exp_a.delete(); starts_a.delete();
        tx_words_b.delete(); rx_words_b.delete(); exp_b.delete(); starts_b.delete();

        // Back-to-back burst larger than the FIFO
        for (int i = 0; i < 5; i++) push_a(12'($urandom));
        check("burst_in_ready_full", 32'(in_ready_a), 32'd0);
        last_word = exp_a[4];
        wait_idle("burst");
        check("burst_frames", 32'(starts_a.size()), 32'd5);
        for (int i = 0; i + 1 < starts_a.size(); i++)
            check($sformatf("burst_gap_%0d", i), 32'(starts_a[i+1] - starts_a[i] - 12), 32'd2);
        cmp_q("burst_tx", tx_words_a, exp_a);
        cmp_q("burst_rx", rx_words_a, exp_a);
        tx_words_a.delete(); rx_words_a.delete(); exp_a.delete(); starts_a.delete();

        // Directly driven RX: partial words abort, a full word completes
        loop_a = 1'b0;
        v0 = valids_a;
        a0 = aborts_a;
        drive_rx_a(5, w);
        cycles(3);
        check("abort5_pulses", 32'(aborts_a - a0), 32'd1);
        check("abort5_no_valid", 32'(valids_a - v0), 32'd0);
        check("abort5_rx_data_held", 32'(rx_data_a), last_word);
        drive_rx_a(11, w);
        cycles(3);
        check("abort11_pulses", 32'(aborts_a - a0), 32'd2);
        check("abort11_rx_data_held", 32'(rx_data_a), last_word);
        drive_rx_a(12, w);
        cycles(3);
        check("full12_valid", 32'(valids_a - v0), 32'd1);
        check("full12_rx_data", 32'(rx_data_a), w);
        check("full12_no_abort", 32'(aborts_a - a0), 32'd2);
        rx_words_a.delete();
        loop_a = 1'b1;

        // Instance B: LSB-first single word, then two queued words with no gap
        push_b(8'h01);
        wait_idle("lsb");
        check("lsb_first_bit", 32'(last_b.size() > 0 ? last_b[0] : 1'b0), 32'd1);
        check("lsb_rest_zero", pack_bits(last_b, 1'b1) >> 1, 32'd0);
        check("lsb_rx_data", 32'(rx_data_b), 32'h01);
        tx_words_b.delete(); rx_words_b.delete(); exp_b.delete(); starts_b.delete();
        push_b(8'($urandom));
        push_b(8'($urandom));
        wait_idle("gap0");
        check("gap0_frames", 32'(starts_b.size()), 32'd2);
        if (starts_b.size() == 2) check("gap0_gap", 32'(starts_b[1] - starts_b[0] - 8), 32'd1);
        cmp_q("gap0_rx", rx_words_b, exp_b);
        check("b_no_abort", 32'(aborts_b), 32'd0);

        check("idle_line_high", 32'(idle_hi), 32'd0);
        check("truncated_frames", 32'(trunc), 32'd0);
        check("loopback_aborts", 32'(aborts_a - a0), 32'd2);

        // Reset during bit 6 of a frame with two words still queued
        for (int i = 0; i < 3; i++) push_a(12'($urandom));
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ser_en_a) begin seen = 1'b1; break; end
        end
        check("midrst_frame_seen", 32'(seen), 32'd1);
        repeat (6) @(negedge clk);
        v0 = valids_a;
        a0 = aborts_a;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        cycles(3);
        @(negedge clk) rst = 1'b0;
        fs = starts_a.size();
        cycles(40);
        check("midrst_no_new_frame", 32'(starts_a.size() - fs), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_no_valid", 32'(valids_a - v0), 32'd0);
        check("midrst_no_abort", 32'(aborts_a - a0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_serdes_param.md
FRAME_SERDES_PARAM -- requirements
Module: frame_serdes_param

Interface
REQ-001 Parameter WORD_W, default 12, SHALL set the serial word width in bits (legal 4..32).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the TX FIFO depth in words (power of two, 2..16).
REQ-003 Parameter LSB_FIRST, default 0, SHALL select the bit order: 0 is MSB first, 1 is LSB first, on both TX and RX.
REQ-004 Parameter GAP_CYCLES, default 1, SHALL set the idle cycles inserted between consecutive TX frames (0..15).
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-007 in_data  input  WORD_W  TX word to send.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  FIFO can accept a word; a transfer occurs on in_valid and in_ready both high.
REQ-010 ser_out  output  1  serial TX bit.
REQ-011 ser_en  output  1  high while ser_out carries a frame bit.
REQ-012 busy  output  1  high when the TX FSM is not in IDLE or the FIFO is non-empty.
REQ-013 ser_in  input  1  serial RX bit.
REQ-014 ser_in_en  input  1  qualifies ser_in as a frame bit.
REQ-015 rx_data  output  WORD_W  last reassembled word.
REQ-016 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-017 rx_abort  output  1  one-cycle pulse, partial RX word discarded.

Function
REQ-018 The TX FIFO SHALL be a synchronous FIFO; in_ready = !full, computed from registered occupancy only, so a pop in the same cycle does not raise in_ready when full.
REQ-019 The TX FSM SHALL have states IDLE, LOAD, SHIFT and GAP.
REQ-020 IDLE -> LOAD when the FIFO is non-empty; LOAD pops one word into the shift register; LOAD -> SHIFT unconditionally.
REQ-021 SHIFT SHALL last exactly WORD_W cycles with ser_en=1, one bit per cycle in LSB_FIRST order; a bit counter of width $clog2(WORD_W) SHALL count 0..WORD_W-1.
REQ-022 After the last bit, SHIFT -> GAP if GAP_CYCLES>0, else -> LOAD if the FIFO is non-empty, else -> IDLE.
REQ-023 GAP SHALL hold ser_en=0 for GAP_CYCLES cycles, then go to LOAD if the FIFO is non-empty, else IDLE.
REQ-024 ser_out SHALL be 0 whenever ser_en=0.
REQ-025 TX latency: a word written into an empty FIFO with the FSM in IDLE at edge t SHALL present its first bit with ser_en=1 in the cycle after edge t+2.
REQ-026 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 The RX side SHALL shift ser_in into a WORD_W register on every cycle with ser_in_en=1 and count the received bits.
REQ-028 On the WORD_W-th qualified bit, the RX side SHALL register the assembled word into rx_data, pulse rx_valid in the next cycle, and clear the counter; rx_data SHALL hold until the next completed word.
REQ-029 If ser_in_en falls while the RX count is non-zero and below WORD_W, the RX side SHALL discard the partial word, clear the counter, pulse rx_abort, and leave rx_data unchanged.
REQ-030 RX SHALL be independent of TX; ser_out looped to ser_in with ser_en looped to ser_in_en SHALL reproduce each TX word on rx_data.

Reset
REQ-031 While rst is high: FSM=IDLE, FIFO empty, all counters 0, ser_out=0, ser_en=0, busy=0, in_ready=1, rx_data=0, rx_valid=0, rx_abort=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame and flush the FIFO, with no rx_valid or rx_abort pulse.

Structure
REQ-033 Package serdes_pkg SHALL hold the TX state encoding (IDLE=0, LOAD=1, SHIFT=2, GAP=3) and the shared width-function constants.
REQ-034 The FIFO SHALL be the sub-module sync_fifo (parameters WIDTH, DEPTH); the TX FSM, PISO and SIPO SHALL live in frame_serdes_param.

Verification
REQ-035 Loopback, default params, push 0xA5C -> ser_out 1,0,1,0,0,1,0,1,1,1,0,0 over 12 cycles; rx_data=0xA5C with rx_valid pulse.
REQ-036 LSB_FIRST=1, WORD_W=8, push 0x01 -> first serial bit 1, then seven 0s; rx_data=0x01.
REQ-037 Push 5 words back-to-back with FIFO_DEPTH=4 and no drain -> in_ready low after the 4th; all 5 words arrive in order, each separated by exactly GAP_CYCLES+1 cycles of ser_en=0.
REQ-038 Drive ser_in_en for 5 cycles, then drop it -> rx_abort pulses once, rx_valid stays 0, rx_data keeps its prior value.
REQ-039 Assert rst during SHIFT bit 6 with 2 words queued -> outputs at reset values immediately; after release, no frame is sent and busy=0.
REQ-040 GAP_CYCLES=0 with 2 queued words -> exactly one ser_en=0 cycle (LOAD) between frames.
